game_scene_ctrl: RTL

GAME_SCENE_CTRL -- requirements
Module: game_scene_ctrl

---
 rtl/game_scene_ctrl.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/game_scene_ctrl.sv
// Scene sequencer: decodes game events, switches the video source on a frame boundary, then blanks.
// Latency: video/sync out 1 cycle after input; scene commits at the first selected-vsync fall after a request.
// No backpressure: events arriving while busy are dropped, not queued.
module game_scene_ctrl #(
    parameter int RW           = 3,
    parameter int GW           = 3,
    parameter int BW           = 2,
    parameter int BLANK_FRAMES = 2,
    parameter int CNTW         = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            key_start,
    input  logic            key_restart,
    input  logic            maze_exit,
    input  logic            battle_enter,
    input  logic            battle_win,
    input  logic            battle_lose,
    input  logic [4*RW-1:0] src_r,
    input  logic [4*GW-1:0] src_g,
    input  logic [4*BW-1:0] src_b,
    input  logic [3:0]      src_hs,
    input  logic [3:0]      src_vs,
    output logic [RW-1:0]   r,
    output logic [GW-1:0]   g,
    output logic [BW-1:0]   b,
    output logic            hs,
    output logic            vs,
    output logic [1:0]      state,
    output logic [3:0]      key_en,
    output logic            busy,
    output logic            won,
    output logic [CNTW-1:0] battles
);

    typedef enum logic [1:0] {
        S_START  = 2'd0,
        S_MAZE   = 2'd1,
        S_BATTLE = 2'd2,
        S_END    = 2'd3
    } scene_e;

    localparam logic [3:0] BLANK_INIT = BLANK_FRAMES[3:0];

    scene_e          state_q, state_d;
    scene_e          target_q, target_d;
    logic            pending_q, pending_d;
    logic            won_tgt_q, won_tgt_d;
    logic [3:0]      blank_q, blank_d;
    logic            won_q, won_d;
    logic [CNTW-1:0] battles_q, battles_d;
    logic            vs_d_q, vs_d_d;
    logic [RW-1:0]   r_q, r_d;
    logic [GW-1:0]   g_q, g_d;
    logic [BW-1:0]   b_q, b_d;
    logic            hs_q, hs_d;
    logic            vs_q, vs_d;

    // Per-source unpacked views of the packed colour buses
    logic [RW-1:0] src_r_a [4];
    logic [GW-1:0] src_g_a [4];
    logic [BW-1:0] src_b_a [4];

    for (genvar k = 0; k < 4; k++) begin : g_src
        assign src_r_a[k] = src_r[k*RW +: RW];
        assign src_g_a[k] = src_g[k*GW +: GW];
        assign src_b_a[k] = src_b[k*BW +: BW];
    end

    logic   sel_vs;
    logic   boundary;
    logic   commit;
    logic   busy_w;
    logic   req_vld;
    scene_e req_tgt;
    logic   req_won;

    assign sel_vs   = src_vs[state_q];
    // Falling edge of the selected vsync; vs_d_q is cleared on commit so the source swap cannot fake one
    assign boundary = vs_d_q & ~sel_vs;
    assign commit   = pending_q & boundary;
    assign busy_w   = pending_q | (blank_q != 4'd0);

    // Event decode and scene/blank/score next-state
    always_comb begin
        req_vld   = 1'b0;
        req_tgt   = state_q;
        req_won   = 1'b0;
        state_d   = state_q;
        target_d  = target_q;
        pending_d = pending_q;
        won_tgt_d = won_tgt_q;
        blank_d   = blank_q;
        won_d     = won_q;
        battles_d = battles_q;
        vs_d_d    = sel_vs;

        // Requests are only looked at when idle; pending is never set while busy
        if (!busy_w) begin
            case (state_q)
                S_START: begin
                    if (key_start) begin
                        req_vld = 1'b1;
                        req_tgt = S_MAZE;
                    end
                end
                S_MAZE: begin
                    if (maze_exit) begin
                        req_vld = 1'b1;
                        req_tgt = S_END;
                        req_won = 1'b1;
                    end else if (battle_enter) begin
                        req_vld = 1'b1;
                        req_tgt = S_BATTLE;
                    end
                end
                S_BATTLE: begin
                    if (battle_lose) begin
                        req_vld = 1'b1;
                        req_tgt = S_END;
                    end else if (battle_win) begin
                        req_vld = 1'b1;
                        req_tgt = S_MAZE;
                    end
                end
                default: begin
                    if (key_restart) begin
                        req_vld = 1'b1;
                        req_tgt = S_START;
                    end
                end
            endcase
        end

        // pending_q is 0 whenever a request is accepted, so a same-cycle boundary cannot commit it
        if (req_vld) begin
            target_d  = req_tgt;
            pending_d = 1'b1;
            won_tgt_d = req_won;
        end

        if (commit) begin
            state_d   = target_q;
            pending_d = 1'b0;
            blank_d   = BLANK_INIT;
            vs_d_d    = 1'b0;
            case (target_q)
                S_BATTLE: begin
                    if (battles_q != '1) begin
                        battles_d = battles_q + 1'b1;
                    end
                end
                S_START: begin
                    battles_d = '0;
                    won_d     = 1'b0;
                end
                S_END: begin
                    won_d = won_tgt_q;
                end
                default: ;
            endcase
        end else if (boundary && (blank_q != 4'd0)) begin
            blank_d = blank_q - 4'd1;
        end
    end

    // Video mux: colour forced black while blanking, syncs always pass
    always_comb begin
        r_d  = (blank_q != 4'd0) ? '0 : src_r_a[state_q];
        g_d  = (blank_q != 4'd0) ? '0 : src_g_a[state_q];
        b_d  = (blank_q != 4'd0) ? '0 : src_b_a[state_q];
        hs_d = src_hs[state_q];
        vs_d = src_vs[state_q];
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_START;
            target_q  <= S_START;
            pending_q <= 1'b0;
            won_tgt_q <= 1'b0;
            blank_q   <= 4'd0;
            won_q     <= 1'b0;
            battles_q <= '0;
            vs_d_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            pending_q <= pending_d;
            won_tgt_q <= won_tgt_d;
            blank_q   <= blank_d;
            won_q     <= won_d;
            battles_q <= battles_d;
            vs_d_q    <= vs_d_d;
        end
    end

    // Video output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
            hs_q <= 1'b1;
            vs_q <= 1'b1;
        end else begin
            r_q  <= r_d;
            g_q  <= g_d;
            b_q  <= b_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
        end
    end

    assign r       = r_q;
    assign g       = g_q;
    assign b       = b_q;
    assign hs      = hs_q;
    assign vs      = vs_q;
    assign state   = state_q;
    assign key_en  = 4'b0001 << state_q;
    assign busy    = busy_w;
    assign won     = won_q;
    assign battles = battles_q;

endmodule
